// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset control FSM: sequences a shared memory/ALU datapath,
// flags unsupported instructions and counts retired instructions.
module multicycle_control_unit #(
   parameter int ALU_CTRL_W = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  pc_wrt,
   output logic                  ir_wrt,
   output logic                  mem_rd,
   output logic                  mem_wrt,
   output logic                  reg_wrt,
   output logic                  adr_src,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            result_src,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic [1:0]            imm_src,
   output logic                  illegal,
   output logic [CNT_W-1:0]      instret
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
      S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_instret;
   logic             w_retire;

   logic [6:0] w_op;
   logic [2:0] w_f3;
   logic       w_f7b5;
   logic       w_is_lw, w_is_sw, w_is_r, w_is_i, w_is_br, w_is_jal, w_is_jalr;
   logic [3:0] w_alu_f3;
   logic       w_unused;

   assign w_op     = instr[6:0];
   assign w_f3     = instr[14:12];
   assign w_f7b5   = instr[30];
   assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

   assign w_is_lw   = (w_op == OP_LOAD)  && (w_f3 == 3'b010);
   assign w_is_sw   = (w_op == OP_STORE) && (w_f3 == 3'b010);
   assign w_is_r    = (w_op == OP_RTYPE) &&
                      (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110 || w_f3 == 3'b010);
   assign w_is_i    = (w_op == OP_ITYPE) &&
                      (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110);
   assign w_is_br   = (w_op == OP_BRANCH) && (w_f3 == 3'b000 || w_f3 == 3'b001);
   assign w_is_jal  = (w_op == OP_JAL);
   assign w_is_jalr = (w_op == OP_JALR) && (w_f3 == 3'b000);

   // funct3 -> ALU op shared by R-type and I-type; sub is selected separately in EXECR
   always_comb begin
      case (w_f3)
         3'b111:  w_alu_f3 = ALU_AND;
         3'b110:  w_alu_f3 = ALU_OR;
         3'b010:  w_alu_f3 = ALU_SLT;
         default: w_alu_f3 = ALU_ADD;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            if (w_is_lw || w_is_sw) w_next = S_MEMADR;
            else if (w_is_r)        w_next = S_EXECR;
            else if (w_is_i)        w_next = S_EXECI;
            else if (w_is_br)       w_next = S_BRANCH;
            else if (w_is_jal)      w_next = S_JAL;
            else if (w_is_jalr)     w_next = S_JALR;
            else                    w_next = S_TRAP;
         end
         S_MEMADR: w_next = w_is_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR:  if (mem_ready) w_next = S_FETCH;
         S_EXECR:  w_next = S_ALUWB;
         S_EXECI:  w_next = S_ALUWB;
         S_ALUWB:  w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JALR:   w_next = S_JAL;
         S_JAL:    w_next = S_ALUWB;
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_FETCH;
      endcase
   end

   assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                     (r_state == S_BRANCH) || ((r_state == S_MEMWR) && mem_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_instret <= r_instret + 1'b1;
      end
   end

   assign instret = r_instret;

   always_comb begin
      pc_wrt     = 1'b0;
      ir_wrt     = 1'b0;
      mem_rd     = 1'b0;
      mem_wrt    = 1'b0;
      reg_wrt    = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_ctrl   = '0;
      imm_src    = 2'b00;
      illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_rd     = 1'b1;
            alu_src_b  = 2'b10;
            alu_ctrl   = ALU_CTRL_W'(ALU_ADD);
            result_src = 2'b10;
            ir_wrt     = mem_ready;
            pc_wrt     = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
            case (w_op)
               OP_STORE:  imm_src = 2'b01;
               OP_BRANCH: imm_src = 2'b10;
               OP_JAL:    imm_src = 2'b11;
               default:   imm_src = 2'b00;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
            imm_src   = w_is_lw ? 2'b00 : 2'b01;
         end
         S_MEMRD: begin
            mem_rd  = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_wrt    = 1'b1;
         end
         S_MEMWR: begin
            mem_wrt = 1'b1;
            adr_src = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_ctrl  = (w_f3 == 3'b000 && w_f7b5) ? ALU_CTRL_W'(ALU_SUB)
                                                    : ALU_CTRL_W'(w_alu_f3);
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_CTRL_W'(w_alu_f3);
         end
         S_ALUWB: reg_wrt = 1'b1;
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_ctrl  = ALU_CTRL_W'(ALU_SUB);
            pc_wrt    = (w_f3 == 3'b000) ? zero : !zero;
         end
         S_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
         end
         // PC takes the target held in ALUOut while the ALU forms the link address
         S_JAL: begin
            pc_wrt    = 1'b1;
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
         end
         S_TRAP:  illegal = 1'b1;
         default: ;
      endcase
      if (rst) begin
         pc_wrt  = 1'b0;
         ir_wrt  = 1'b0;
         mem_rd  = 1'b0;
         mem_wrt = 1'b0;
         reg_wrt = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class cycle by
// cycle and compares the full control word against hand-derived values.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;

   logic        pc_wrt, ir_wrt, mem_rd, mem_wrt, reg_wrt, adr_src, illegal;
   logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
   logic [3:0]  alu_ctrl;
   logic [31:0] instret;

   logic        n_pc_wrt, n_ir_wrt, n_mem_rd, n_mem_wrt, n_reg_wrt, n_adr_src, n_illegal;
   logic [1:0]  n_alu_src_a, n_alu_src_b, n_result_src, n_imm_src;
   logic [3:0]  n_alu_ctrl;
   logic [3:0]  n_instret;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.ALU_CTRL_W(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .pc_wrt(pc_wrt), .ir_wrt(ir_wrt), .mem_rd(mem_rd), .mem_wrt(mem_wrt),
      .reg_wrt(reg_wrt), .adr_src(adr_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src), .alu_ctrl(alu_ctrl),
      .imm_src(imm_src), .illegal(illegal), .instret(instret)
   );

   multicycle_control_unit #(.ALU_CTRL_W(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .pc_wrt(n_pc_wrt), .ir_wrt(n_ir_wrt), .mem_rd(n_mem_rd), .mem_wrt(n_mem_wrt),
      .reg_wrt(n_reg_wrt), .adr_src(n_adr_src), .alu_src_a(n_alu_src_a),
      .alu_src_b(n_alu_src_b), .result_src(n_result_src), .alu_ctrl(n_alu_ctrl),
      .imm_src(n_imm_src), .illegal(n_illegal), .instret(n_instret)
   );

   // Control word: {pc_wrt,ir_wrt,mem_rd,mem_wrt,reg_wrt, adr_src, a, b, result_src, alu_ctrl, imm_src, illegal}
   logic [18:0] w_obs;
   assign w_obs = {pc_wrt, ir_wrt, mem_rd, mem_wrt, reg_wrt, adr_src, alu_src_a,
                   alu_src_b, result_src, alu_ctrl, imm_src, illegal};

   localparam logic [18:0] E_RST     = {5'b00000, 1'b0, 2'b00, 2'b10, 2'b10, 4'b0010, 2'b00, 1'b0};
   localparam logic [18:0] E_FETCH   = {5'b11100, 1'b0, 2'b00, 2'b10, 2'b10, 4'b0010, 2'b00, 1'b0};
   localparam logic [18:0] E_FWAIT   = {5'b00100, 1'b0, 2'b00, 2'b10, 2'b10, 4'b0010, 2'b00, 1'b0};
   localparam logic [18:0] E_DEC_I   = {5'b00000, 1'b0, 2'b01, 2'b01, 2'b00, 4'b0010, 2'b00, 1'b0};
   localparam logic [18:0] E_DEC_S   = {5'b00000, 1'b0, 2'b01, 2'b01, 2'b00, 4'b0010, 2'b01, 1'b0};
   localparam logic [18:0] E_DEC_B   = {5'b00000, 1'b0, 2'b01, 2'b01, 2'b00, 4'b0010, 2'b10, 1'b0};
   localparam logic [18:0] E_DEC_J   = {5'b00000, 1'b0, 2'b01, 2'b01, 2'b00, 4'b0010, 2'b11, 1'b0};
   localparam logic [18:0] E_EXR_ADD = {5'b00000, 1'b0, 2'b10, 2'b00, 2'b00, 4'b0010, 2'b00, 1'b0};
   localparam logic [18:0] E_EXR_SUB = {5'b00000, 1'b0, 2'b10, 2'b00, 2'b00, 4'b0011, 2'b00, 1'b0};
   localparam logic [18:0] E_EXR_SLT = {5'b00000, 1'b0, 2'b10, 2'b00, 2'b00, 4'b0100, 2'b00, 1'b0};
   localparam logic [18:0] E_EXI_ADD = {5'b00000, 1'b0, 2'b10, 2'b01, 2'b00, 4'b0010, 2'b00, 1'b0};
   localparam logic [18:0] E_MADR_S  = {5'b00000, 1'b0, 2'b10, 2'b01, 2'b00, 4'b0010, 2'b01, 1'b0};
   localparam logic [18:0] E_MEMRD   = {5'b00100, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0};
   localparam logic [18:0] E_MEMWB   = {5'b00001, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00, 1'b0};
   localparam logic [18:0] E_MEMWR   = {5'b00010, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0};
   localparam logic [18:0] E_ALUWB   = {5'b00001, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0};
   localparam logic [18:0] E_BR_T    = {5'b10000, 1'b0, 2'b10, 2'b00, 2'b00, 4'b0011, 2'b00, 1'b0};
   localparam logic [18:0] E_BR_N    = {5'b00000, 1'b0, 2'b10, 2'b00, 2'b00, 4'b0011, 2'b00, 1'b0};
   localparam logic [18:0] E_JAL     = {5'b10000, 1'b0, 2'b01, 2'b10, 2'b00, 4'b0010, 2'b00, 1'b0};
   localparam logic [18:0] E_TRAP    = {5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b1};

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SLT  = 32'h0020A1B3;
   localparam logic [31:0] I_ADDI = 32'h40000093;
   localparam logic [31:0] I_LW   = 32'h00002083;
   localparam logic [31:0] I_SW   = 32'h00102023;
   localparam logic [31:0] I_BEQ  = 32'h00000063;
   localparam logic [31:0] I_BNE  = 32'h00001063;
   localparam logic [31:0] I_JAL  = 32'h000000EF;
   localparam logic [31:0] I_JALR = 32'h000100E7;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to the next negedge, apply inputs, let the combinational outputs settle.
   task automatic cyc(input logic [31:0] iv, input logic mr, input logic z);
      @(negedge clk);
      instr = iv;
      mem_ready = mr;
      zero = z;
      #1;
   endtask

   task automatic fetch_ok(input string tag, input logic [31:0] iv, input int exp_ret);
      cyc(iv, 1'b1, 1'b0);
      check({tag, ".fetch"}, 32'(w_obs), 32'(E_FETCH));
      check({tag, ".instret"}, instret, exp_ret);
      $display("txn %s instr=%h instret=%0d", tag, iv, instret);
   endtask

   task automatic r_type(input string tag, input logic [31:0] iv, input int exp_ret,
                         input logic [18:0] e_exec);
      fetch_ok(tag, iv, exp_ret);
      cyc(iv, 1'b1, 1'b0); check({tag, ".decode"}, 32'(w_obs), 32'(E_DEC_I));
      cyc(iv, 1'b1, 1'b0); check({tag, ".exec"},   32'(w_obs), 32'(e_exec));
      cyc(iv, 1'b1, 1'b0); check({tag, ".aluwb"},  32'(w_obs), 32'(E_ALUWB));
   endtask

   initial begin
      // Reset held: FETCH decode values with every strobe gated off
      #1;
      check("rst.ctrl", 32'(w_obs), 32'(E_RST));
      check("rst.instret", instret, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      check("first.fwait", 32'(w_obs), 32'(E_FWAIT));

      r_type("add", I_ADD, 0, E_EXR_ADD);
      r_type("sub", I_SUB, 1, E_EXR_SUB);
      r_type("slt", I_SLT, 2, E_EXR_SLT);

      fetch_ok("addi", I_ADDI, 3);
      cyc(I_ADDI, 1'b1, 1'b0); check("addi.decode", 32'(w_obs), 32'(E_DEC_I));
      cyc(I_ADDI, 1'b1, 1'b0); check("addi.exec",   32'(w_obs), 32'(E_EXI_ADD));
      cyc(I_ADDI, 1'b1, 1'b0); check("addi.aluwb",  32'(w_obs), 32'(E_ALUWB));

      // lw with three wait cycles in MEMRD: 8 cycles total
      fetch_ok("lw", I_LW, 4);
      cyc(I_LW, 1'b1, 1'b0); check("lw.decode", 32'(w_obs), 32'(E_DEC_I));
      cyc(I_LW, 1'b1, 1'b0); check("lw.memadr", 32'(w_obs), 32'(E_EXI_ADD));
      for (int i = 0; i < 3; i++) begin
         cyc(I_LW, 1'b0, 1'b0); check("lw.memrd_wait", 32'(w_obs), 32'(E_MEMRD));
      end
      cyc(I_LW, 1'b1, 1'b0); check("lw.memrd", 32'(w_obs), 32'(E_MEMRD));
      cyc(I_LW, 1'b1, 1'b0); check("lw.memwb", 32'(w_obs), 32'(E_MEMWB));

      fetch_ok("sw", I_SW, 5);
      cyc(I_SW, 1'b1, 1'b0); check("sw.decode", 32'(w_obs), 32'(E_DEC_S));
      cyc(I_SW, 1'b1, 1'b0); check("sw.memadr", 32'(w_obs), 32'(E_MADR_S));
      cyc(I_SW, 1'b0, 1'b0); check("sw.memwr_wait", 32'(w_obs), 32'(E_MEMWR));
      cyc(I_SW, 1'b1, 1'b0); check("sw.memwr", 32'(w_obs), 32'(E_MEMWR));

      fetch_ok("beq", I_BEQ, 6);
      cyc(I_BEQ, 1'b1, 1'b1); check("beq.decode", 32'(w_obs), 32'(E_DEC_B));
      cyc(I_BEQ, 1'b1, 1'b1); check("beq.branch", 32'(w_obs), 32'(E_BR_T));

      fetch_ok("bne", I_BNE, 7);
      cyc(I_BNE, 1'b1, 1'b1); check("bne.decode", 32'(w_obs), 32'(E_DEC_B));
      cyc(I_BNE, 1'b1, 1'b1); check("bne.branch", 32'(w_obs), 32'(E_BR_N));

      fetch_ok("jal", I_JAL, 8);
      cyc(I_JAL, 1'b1, 1'b0); check("jal.decode", 32'(w_obs), 32'(E_DEC_J));
      cyc(I_JAL, 1'b1, 1'b0); check("jal.jal",    32'(w_obs), 32'(E_JAL));
      cyc(I_JAL, 1'b1, 1'b0); check("jal.aluwb",  32'(w_obs), 32'(E_ALUWB));

      fetch_ok("jalr", I_JALR, 9);
      cyc(I_JALR, 1'b1, 1'b0); check("jalr.decode", 32'(w_obs), 32'(E_DEC_I));
      cyc(I_JALR, 1'b1, 1'b0); check("jalr.jalr",   32'(w_obs), 32'(E_EXI_ADD));
      cyc(I_JALR, 1'b1, 1'b0); check("jalr.jal",    32'(w_obs), 32'(E_JAL));
      cyc(I_JALR, 1'b1, 1'b0); check("jalr.aluwb",  32'(w_obs), 32'(E_ALUWB));

      // Unsupported opcode traps and stays trapped; counter frozen
      fetch_ok("trap", I_BAD, 10);
      cyc(I_BAD, 1'b1, 1'b0); check("trap.decode", 32'(w_obs), 32'(E_DEC_I));
      for (int i = 0; i < 3; i++) begin
         cyc(I_ADD, 1'b1, 1'b0); check("trap.hold", 32'(w_obs), 32'(E_TRAP));
      end
      check("trap.instret", instret, 32'd10);
      check("cnt4.pre", 32'(n_instret), 32'd10);

      // Reset asserted mid-MEMRD of a fresh lw
      @(negedge clk); rst = 1'b1; #1;
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
      check("trap.cleared", 32'(w_obs), 32'(E_FWAIT));
      fetch_ok("lw2", I_LW, 0);
      cyc(I_LW, 1'b1, 1'b0);
      cyc(I_LW, 1'b1, 1'b0);
      cyc(I_LW, 1'b0, 1'b0); check("lw2.memrd", 32'(w_obs), 32'(E_MEMRD));
      @(negedge clk); rst = 1'b1; #1;
      check("rst_mid.ctrl", 32'(w_obs), 32'(E_RST));
      check("rst_mid.instret", instret, 32'd0);
      cyc(I_LW, 1'b1, 1'b0);
      check("rst_mid.hold", 32'(w_obs), 32'(E_RST));
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
      check("rst_mid.fetch", 32'(w_obs), 32'(E_FWAIT));

      // 17 retirements: the 4-bit counter wraps to 1
      for (int k = 0; k < 17; k++) begin
         for (int c = 0; c < 4; c++) cyc(I_ADD, 1'b1, 1'b0);
      end
      cyc(I_ADD, 1'b0, 1'b0);
      check("wrap.fetch", 32'(w_obs), 32'(E_FWAIT));
      check("wrap.instret32", instret, 32'd17);
      check("wrap.instret4", 32'(n_instret), 32'd1);
      $display("txn wrap instret=%0d instret4=%0d", instret, n_instret);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
